// File: rtl/data_mem_unit_if.sv
// Load/store bus between the CPU memory stage and data_mem_unit.
// The master drives requests; the slave returns registered read data and status.
interface data_mem_unit_if #(
    parameter int unsigned DW = 8,
    parameter int unsigned AW = 8
) ();

    logic          MemRead;
    logic          MemWrite;
    logic [AW-1:0] Addr;
    logic [DW-1:0] DataIn;
    logic          Clear;
    logic [DW-1:0] DataMemOut;
    logic          ReadValid;
    logic          AddrErr;
    logic          Busy;

    modport master (
        output MemRead,
        output MemWrite,
        output Addr,
        output DataIn,
        output Clear,
        input  DataMemOut,
        input  ReadValid,
        input  AddrErr,
        input  Busy
    );

    modport slave (
        input  MemRead,
        input  MemWrite,
        input  Addr,
        input  DataIn,
        input  Clear,
        output DataMemOut,
        output ReadValid,
        output AddrErr,
        output Busy
    );

endinterface

// File: rtl/data_mem_unit.sv
// Single-port data RAM with registered read, range checking and a zero-fill engine
// that sweeps the whole array after reset or on Clear.
module data_mem_unit #(
    parameter int unsigned DW             = 8,
    parameter int unsigned AW             = 8,
    parameter int unsigned DEPTH          = 256,
    parameter bit          CLEAR_ON_RESET = 1'b1
) (
    input logic            CLK,
    input logic            Reset_n,
    data_mem_unit_if.slave bus
);

    localparam logic [AW-1:0] LastPtr = AW'(DEPTH - 1);

    typedef enum logic [0:0] {
        StIdle,
        StClear
    } state_e;

    state_e        r_state;
    logic [AW-1:0] r_ptr;
    logic          r_busy;
    logic [DW-1:0] r_dout;
    logic          r_read_valid;
    logic          r_addr_err;

    logic [DW-1:0] r_mem [DEPTH];

    logic          w_in_range;
    logic          w_access;
    logic          w_wr_en;
    logic [DW-1:0] w_rd_data;

    // Zero-extend before comparing so DEPTH == 2**AW never flags an error.
    assign w_in_range = (32'(bus.Addr) < DEPTH);

    // A Clear in IDLE wins over any request presented in the same cycle.
    assign w_access = (r_state == StIdle) && !bus.Clear && (bus.MemRead || bus.MemWrite);
    assign w_wr_en  = w_access && bus.MemWrite && w_in_range;

    always_comb begin
        w_rd_data = '0;
        if (w_in_range) begin
            w_rd_data = bus.MemWrite ? bus.DataIn : r_mem[bus.Addr];
        end
    end

    always_ff @(posedge CLK) begin
        if (r_state == StClear) begin
            r_mem[r_ptr] <= '0;
        end else if (w_wr_en) begin
            r_mem[bus.Addr] <= bus.DataIn;
        end
    end

    always_ff @(posedge CLK or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state      <= CLEAR_ON_RESET ? StClear : StIdle;
            r_busy       <= CLEAR_ON_RESET;
            r_ptr        <= '0;
            r_dout       <= '0;
            r_read_valid <= 1'b0;
            r_addr_err   <= 1'b0;
        end else begin
            r_read_valid <= 1'b0;
            r_addr_err   <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (bus.Clear) begin
                        r_state <= StClear;
                        r_busy  <= 1'b1;
                        r_ptr   <= '0;
                    end else if (w_access) begin
                        r_read_valid <= bus.MemRead;
                        r_addr_err   <= !w_in_range;
                        if (bus.MemRead) begin
                            r_dout <= w_rd_data;
                        end
                    end
                end
                StClear: begin
                    // Busy drops on the same edge that zeroes the last word.
                    if (r_ptr == LastPtr) begin
                        r_state <= StIdle;
                        r_busy  <= 1'b0;
                        r_ptr   <= '0;
                    end else begin
                        r_ptr <= r_ptr + 1'b1;
                    end
                end
                default: begin
                    r_state <= StIdle;
                    r_busy  <= 1'b0;
                    r_ptr   <= '0;
                end
            endcase
        end
    end

    assign bus.DataMemOut = r_dout;
    assign bus.ReadValid  = r_read_valid;
    assign bus.AddrErr    = r_addr_err;
    assign bus.Busy       = r_busy;

endmodule

// File: tb/tb_data_mem_unit.sv
// Scoreboard bench: two instances (DEPTH 256 and DEPTH 200) share one stimulus stream,
// each checked against its own array model and expected-response queue.
module tb_data_mem_unit;

    typedef struct packed {
        logic       rv;
        logic       err;
        logic [7:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       t_rd, t_wr, t_clr;
    logic [7:0] t_addr, t_din;

    int n_chk = 0;
    int n_err = 0;

    logic [7:0]  m_mem   [2][256];
    int          m_depth [2];
    int          m_busy  [2];
    logic [7:0]  m_last  [2];
    exp_t        q0[$];
    exp_t        q1[$];

    always #5 clk = ~clk;

    data_mem_unit_if #(.DW(8), .AW(8)) bus0 ();
    data_mem_unit_if #(.DW(8), .AW(8)) bus1 ();

    assign bus0.MemRead  = t_rd;
    assign bus0.MemWrite = t_wr;
    assign bus0.Clear    = t_clr;
    assign bus0.Addr     = t_addr;
    assign bus0.DataIn   = t_din;
    assign bus1.MemRead  = t_rd;
    assign bus1.MemWrite = t_wr;
    assign bus1.Clear    = t_clr;
    assign bus1.Addr     = t_addr;
    assign bus1.DataIn   = t_din;

    data_mem_unit #(.DW(8), .AW(8), .DEPTH(256), .CLEAR_ON_RESET(1'b1)) u_dut256 (
        .CLK     (clk),
        .Reset_n (rst_n),
        .bus     (bus0)
    );

    data_mem_unit #(.DW(8), .AW(8), .DEPTH(200), .CLEAR_ON_RESET(1'b1)) u_dut200 (
        .CLK     (clk),
        .Reset_n (rst_n),
        .bus     (bus1)
    );

    task automatic chk(input string name, input int d, input logic [15:0] act,
                       input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s dut%0d @%0t: got %0h expected %0h", name, d, $time, act, exp);
        end
    endtask

    function automatic void q_push(input int d, input exp_t e);
        if (d == 0) q0.push_back(e);
        else        q1.push_back(e);
    endfunction

    function automatic int q_size(input int d);
        return (d == 0) ? q0.size() : q1.size();
    endfunction

    function automatic exp_t q_pop(input int d);
        return (d == 0) ? q0.pop_front() : q1.pop_front();
    endfunction

    function automatic void model_reset();
        for (int d = 0; d < 2; d++) begin
            m_busy[d] = m_depth[d];
            m_last[d] = 8'h00;
        end
        q0.delete();
        q1.delete();
    endfunction

    // Predicts the effect of the coming rising edge on one instance.
    function automatic void model_step(input int d);
        exp_t e;
        if (m_busy[d] > 0) begin
            m_mem[d][m_depth[d] - m_busy[d]] = 8'h00;
            m_busy[d]--;
        end else if (t_clr) begin
            m_busy[d] = m_depth[d];
        end else if (t_rd || t_wr) begin
            if (int'(t_addr) >= m_depth[d]) begin
                e.rv = t_rd; e.err = 1'b1; e.data = 8'h00;
                q_push(d, e);
            end else begin
                if (t_wr) m_mem[d][t_addr] = t_din;
                if (t_rd) begin
                    e.rv = 1'b1; e.err = 1'b0; e.data = m_mem[d][t_addr];
                    q_push(d, e);
                end
            end
        end
    endfunction

    // Called at a falling edge; returns at the next falling edge.
    task automatic drive(input logic rd, input logic wr, input logic clr,
                         input logic [7:0] addr, input logic [7:0] din);
        t_rd = rd; t_wr = wr; t_clr = clr; t_addr = addr; t_din = din;
        model_step(0);
        model_step(1);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0, 1'b0, 8'h00, 8'h00);
    endtask

    task automatic do_reset();
        t_rd = 1'b0; t_wr = 1'b0; t_clr = 1'b0;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("async rst Busy", 0, 16'(bus0.Busy), 16'h1);
        chk("async rst ReadValid", 0, 16'(bus0.ReadValid), 16'h0);
        chk("async rst AddrErr", 0, 16'(bus0.AddrErr), 16'h0);
        chk("async rst DataMemOut", 0, 16'(bus0.DataMemOut), 16'h0);
        chk("async rst Busy", 1, 16'(bus1.Busy), 16'h1);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic mon(input int d, input logic busy, input logic rv, input logic err,
                       input logic [7:0] dout);
        exp_t e;
        chk("Busy", d, 16'(busy), 16'(m_busy[d] > 0));
        if (rv || err) begin
            if (q_size(d) == 0) begin
                chk("spurious ReadValid/AddrErr", d, 16'({rv, err}), 16'h0);
            end else begin
                e = q_pop(d);
                chk("ReadValid", d, 16'(rv), 16'(e.rv));
                chk("AddrErr", d, 16'(err), 16'(e.err));
                if (e.rv) m_last[d] = e.data;
                chk("DataMemOut", d, 16'(dout), 16'(m_last[d]));
            end
        end else begin
            if (q_size(d) != 0) begin
                e = q_pop(d);
                chk("missing ReadValid/AddrErr", d, 16'({rv, err}), 16'({e.rv, e.err}));
                if (e.rv) m_last[d] = e.data;
            end
            chk("DataMemOut hold", d, 16'(dout), 16'(m_last[d]));
        end
    endtask

    always @(posedge clk) begin
        #1;
        mon(0, bus0.Busy, bus0.ReadValid, bus0.AddrErr, bus0.DataMemOut);
        mon(1, bus1.Busy, bus1.ReadValid, bus1.AddrErr, bus1.DataMemOut);
    end

    initial begin
        m_depth[0] = 256;
        m_depth[1] = 200;
        for (int d = 0; d < 2; d++) begin
            for (int a = 0; a < 256; a++) m_mem[d][a] = 8'h00;
        end
        model_reset();
        rst_n = 1'b0;
        t_rd = 1'b0; t_wr = 1'b0; t_clr = 1'b0; t_addr = 8'h00; t_din = 8'h00;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;

        // Power-up clear; reads issued while Busy must be dropped.
        for (int i = 0; i < 260; i++) begin
            drive(i[2], 1'b0, 1'b0, 8'(i), 8'h00);
        end
        drive(1'b1, 1'b0, 1'b0, 8'd0,   8'h00);
        drive(1'b1, 1'b0, 1'b0, 8'd128, 8'h00);
        drive(1'b1, 1'b0, 1'b0, 8'd255, 8'h00);

        drive(1'b0, 1'b1, 1'b0, 8'd3, 8'hA5);
        drive(1'b1, 1'b0, 1'b0, 8'd3, 8'h00);
        idle(3);

        drive(1'b0, 1'b1, 1'b0, 8'd7, 8'h11);
        drive(1'b1, 1'b1, 1'b0, 8'd7, 8'h3C);
        drive(1'b1, 1'b0, 1'b0, 8'd7, 8'h00);

        drive(1'b0, 1'b1, 1'b0, 8'd200, 8'hFF);
        drive(1'b1, 1'b0, 1'b0, 8'd200, 8'h00);
        drive(1'b0, 1'b1, 1'b0, 8'd199, 8'h5A);
        drive(1'b1, 1'b0, 1'b0, 8'd199, 8'h00);
        idle(2);

        // Random traffic around both ends of the address space, with rare clears.
        for (int i = 0; i < 400; i++) begin
            logic [7:0] a;
            a = ($urandom % 2 == 0) ? 8'($urandom_range(0, 15)) : 8'($urandom_range(190, 255));
            drive(1'($urandom % 2), 1'($urandom % 3 == 0), 1'($urandom % 150 == 0),
                  a, 8'($urandom));
        end
        idle(260);

        // Fill, clear (with a second Clear and reads while Busy), then read back.
        for (int a = 0; a < 10; a++) drive(1'b0, 1'b1, 1'b0, 8'(a), 8'(a + 1));
        drive(1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
        for (int i = 0; i < 258; i++) begin
            drive(1'b1, 1'b0, (i == 20), 8'(i % 10), 8'h00);
        end
        for (int a = 0; a < 10; a++) drive(1'b1, 1'b0, 1'b0, 8'(a), 8'h00);

        // Reset at clear-cycle 50; the sweep restarts from address 0.
        for (int a = 0; a < 4; a++) drive(1'b0, 1'b1, 1'b0, 8'(a + 250), 8'hC3);
        drive(1'b0, 1'b0, 1'b1, 8'h00, 8'h00);
        idle(50);
        do_reset();
        for (int i = 0; i < 258; i++) drive(1'b1, 1'b0, 1'b0, 8'(250 + i % 6), 8'h00);
        for (int a = 250; a < 256; a++) drive(1'b1, 1'b0, 1'b0, 8'(a), 8'h00);
        idle(3);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
